// File: rtl/match_flow_ctrl.sv
// Game-flow controller for the penalty simulator: START/KEEPER/SHOOTER/WINNER/LOSER
// sequencing in SOLO and MULTI modes, with link sync, turn timeout and link-loss recovery.
//
// state   | meaning
// START   | menu; waiting for a click (SOLO) or a synced peer start (MULTI)
// KEEPER  | local player is goalkeeper
// SHOOTER | local player is shooter
// WINNER  | result screen, local win
// LOSER   | result screen, local loss
module match_flow_ctrl #(
    parameter int SYNC_CYCLES  = 1_000_000,
    parameter int TURN_TIMEOUT = 0,
    parameter int LINK_GRACE   = 1024,
    parameter int RESULT_HOLD  = 0,
    parameter int TURN_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              left_clicked,
    input  logic              right_clicked,
    input  logic              solo_enable,
    input  logic              connect_ok,
    input  logic              enemy_shooter,
    input  logic              game_starts,
    input  logic              match_end,
    input  logic              match_result,
    input  logic              end_gk,
    input  logic              end_sh,
    input  logic              back_to_start,
    output logic [2:0]        game_state,
    output logic              game_mode,
    output logic [7:0]        tx_data,
    output logic              turn_timeout,
    output logic              link_lost,
    output logic [TURN_W-1:0] turn_cnt
);

    localparam int SYNC_W = $clog2(SYNC_CYCLES + 2);
    localparam int TMR_W  = $clog2(TURN_TIMEOUT + 2);
    localparam int LINK_W = $clog2(LINK_GRACE + 1);
    localparam int RES_W  = $clog2(RESULT_HOLD + 2);

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_KEEPER  = 3'd1,
        ST_SHOOTER = 3'd2,
        ST_WINNER  = 3'd3,
        ST_LOSER   = 3'd4
    } state_t;

    state_t            state;
    logic [SYNC_W-1:0] sync_cnt;
    logic [TMR_W-1:0]  turn_tmr;
    logic [LINK_W-1:0] link_cnt;
    logic [RES_W-1:0]  res_tmr;

    logic       in_turn;
    logic       in_result;
    logic       turn_exp;
    logic       res_exp;
    logic       link_fire;
    logic       tmo_fire;
    logic       swap;
    logic [7:0] tx_next;

    assign game_state = state;

    always_comb begin
        in_turn   = (state == ST_KEEPER) || (state == ST_SHOOTER);
        in_result = (state == ST_WINNER) || (state == ST_LOSER);
        turn_exp  = 1'b0;
        res_exp   = 1'b0;
        if (TURN_TIMEOUT > 0 && in_turn && turn_tmr == TMR_W'(TURN_TIMEOUT - 1))
            turn_exp = 1'b1;
        if (RESULT_HOLD > 0 && in_result && res_tmr == RES_W'(RESULT_HOLD - 1))
            res_exp = 1'b1;
        link_fire = !game_mode && !connect_ok && (in_turn || in_result)
                    && (link_cnt == LINK_W'(LINK_GRACE - 1));
        // match_end and link loss both pre-empt an expiring turn, so no pulse then
        tmo_fire  = turn_exp && !match_end && !link_fire;
        swap      = ((state == ST_KEEPER) && end_gk) || ((state == ST_SHOOTER) && end_sh)
                    || turn_exp;
        if (left_clicked)       tx_next = 8'hC8;
        else if (right_clicked) tx_next = 8'h28;
        else if (game_starts)   tx_next = 8'h48;
        else if (tmo_fire)      tx_next = 8'h18;
        else                    tx_next = 8'h08;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_START;
            game_mode    <= 1'b0;
            tx_data      <= 8'h00;
            turn_timeout <= 1'b0;
            link_lost    <= 1'b0;
            turn_cnt     <= '0;
            sync_cnt     <= '0;
            turn_tmr     <= '0;
            link_cnt     <= '0;
            res_tmr      <= '0;
        end else begin
            tx_data      <= tx_next;
            turn_timeout <= tmo_fire;
            case (state)
                ST_START: begin
                    game_mode <= solo_enable;
                    turn_tmr  <= '0;
                    link_cnt  <= '0;
                    res_tmr   <= '0;
                    if (!connect_ok)
                        sync_cnt <= '0;
                    else if (sync_cnt != SYNC_W'(SYNC_CYCLES))
                        sync_cnt <= sync_cnt + 1'b1;
                    if (game_mode) begin
                        if (left_clicked) begin
                            state     <= ST_KEEPER;
                            turn_cnt  <= '0;
                            link_lost <= 1'b0;
                            sync_cnt  <= '0;
                        end
                    end else if (sync_cnt == SYNC_W'(SYNC_CYCLES) && game_starts) begin
                        state     <= enemy_shooter ? ST_SHOOTER : ST_KEEPER;
                        turn_cnt  <= '0;
                        link_lost <= 1'b0;
                        sync_cnt  <= '0;
                    end
                end

                ST_KEEPER, ST_SHOOTER: begin
                    sync_cnt <= '0;
                    res_tmr  <= '0;
                    link_cnt <= (game_mode || connect_ok) ? '0 : link_cnt + 1'b1;
                    turn_tmr <= (TURN_TIMEOUT > 0) ? turn_tmr + 1'b1 : '0;
                    if (link_fire) begin
                        state     <= ST_START;
                        link_lost <= 1'b1;
                        link_cnt  <= '0;
                        turn_tmr  <= '0;
                    end else if (match_end) begin
                        state    <= match_result ? ST_WINNER : ST_LOSER;
                        turn_tmr <= '0;
                    end else if (game_mode) begin
                        // SOLO keeps the keeper role; expiry only restarts the turn
                        if (turn_exp)
                            turn_tmr <= '0;
                    end else if (swap) begin
                        state    <= (state == ST_KEEPER) ? ST_SHOOTER : ST_KEEPER;
                        turn_tmr <= '0;
                        if (turn_cnt != '1)
                            turn_cnt <= turn_cnt + 1'b1;
                    end
                end

                ST_WINNER, ST_LOSER: begin
                    sync_cnt <= '0;
                    turn_tmr <= '0;
                    link_cnt <= (game_mode || connect_ok) ? '0 : link_cnt + 1'b1;
                    res_tmr  <= (RESULT_HOLD > 0) ? res_tmr + 1'b1 : '0;
                    if (link_fire) begin
                        state     <= ST_START;
                        link_lost <= 1'b1;
                        link_cnt  <= '0;
                        res_tmr   <= '0;
                    end else if (right_clicked || res_exp || (!game_mode && back_to_start)) begin
                        state    <= ST_START;
                        link_cnt <= '0;
                        res_tmr  <= '0;
                    end
                end

                default: begin
                    state    <= ST_START;
                    turn_cnt <= '0;
                    sync_cnt <= '0;
                    turn_tmr <= '0;
                    link_cnt <= '0;
                    res_tmr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/match_flow_ctrl.md
Name: match_flow_ctrl

Overview:
- Parametrised top-level game-flow controller for the penalty simulator. Successor to the fixed-constant next-state selector.
- Sequences START / KEEPER / SHOOTER / WINNER / LOSER in SOLO and MULTI modes.
- Adds configurable link-sync delay, per-turn timeout with forced role swap, link-loss recovery with grace period, auto-return from result screens, and a turn counter.
- Sits between the mouse/UART-link front end and the screen/gameplay logic; drives the sync byte sent to the peer board.

Parameters:
- SYNC_CYCLES, 1_000_000: consecutive connect_ok-high cycles required in START before a MULTI match may begin.
- TURN_TIMEOUT, 0: cycles allowed per KEEPER/SHOOTER turn; 0 disables the timeout.
- LINK_GRACE, 1024: consecutive connect_ok-low cycles tolerated mid-match (MULTI); must be >= 1.
- RESULT_HOLD, 0: cycles before WINNER/LOSER auto-returns to START; 0 disables auto-return.
- TURN_W, 5: width of turn_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- left_clicked  in  1  one-cycle mouse left pulse
- right_clicked  in  1  one-cycle mouse right pulse
- solo_enable  in  1  mode switch; 1 = SOLO
- connect_ok  in  1  peer link valid
- enemy_shooter  in  1  peer takes the first shot
- game_starts  in  1  peer start indication
- match_end  in  1  match finished (pulse)
- match_result  in  1  1 = local win; qualified by match_end
- end_gk  in  1  keeper turn finished (pulse)
- end_sh  in  1  shooter turn finished (pulse)
- back_to_start  in  1  peer requests return to START
- game_state  out  3  START=0, KEEPER=1, SHOOTER=2, WINNER=3, LOSER=4
- game_mode  out  1  0 = MULTI, 1 = SOLO
- tx_data  out  8  sync byte to the peer
- turn_timeout  out  1  one-cycle pulse on turn expiry
- link_lost  out  1  sticky: the match was aborted by link loss
- turn_cnt  out  TURN_W  role swaps in the current match

Behaviour:
- Reset values: game_state=START, game_mode=MULTI, tx_data=0x00, turn_timeout=0, link_lost=0, turn_cnt=0, all internal counters 0.
- All outputs are registered. Inputs sampled at edge N take effect at edge N+1.
- game_mode: loads solo_enable every cycle while in START; frozen in every other state. START transitions use the registered game_mode, so a solo_enable change in the same cycle as a click is ignored for that click.

SOLO state machine:
- START -> KEEPER on left_clicked.
- KEEPER -> WINNER/LOSER on match_end, per match_result.
- end_gk is ignored.
- Timeout pulses turn_timeout and restarts the turn timer; state stays KEEPER.
- WINNER/LOSER -> START on right_clicked or RESULT_HOLD expiry; back_to_start is ignored.

MULTI START and sync:
- sync_cnt increments while connect_ok=1 and saturates at SYNC_CYCLES. It clears to 0 on any connect_ok=0 cycle.
- When sync_cnt==SYNC_CYCLES and game_starts=1: go to SHOOTER if enemy_shooter=1, else KEEPER.
- Otherwise stay in START.

MULTI KEEPER/SHOOTER, priority high to low:
1. Link loss: link_cnt counts consecutive connect_ok=0 cycles. On reaching LINK_GRACE -> START and set link_lost. Any connect_ok=1 cycle clears link_cnt.
2. match_end -> WINNER if match_result=1, else LOSER.
3. Swap: end_gk (KEEPER) or end_sh (SHOOTER) or timer expiry -> opposite role. turn_cnt increments, saturating at all-ones.
4. Otherwise hold.

MULTI WINNER/LOSER:
- Link loss (same rule as above) -> START.
- right_clicked, back_to_start, or RESULT_HOLD expiry -> START.
- link_lost is not set on this path unless the link-loss rule fires.

Turn timer:
- Clears on every state change.
- Counts in KEEPER/SHOOTER when TURN_TIMEOUT>0.
- Expiry is the cycle it equals TURN_TIMEOUT-1. turn_timeout is asserted on the edge that applies the resulting transition.
- If match_end coincides with expiry, match_end wins and no pulse is emitted.

Result timer:
- Counts in WINNER/LOSER; expiry at RESULT_HOLD-1.
- right_clicked on the same cycle as expiry is equivalent to a single return.

turn_cnt and link_lost:
- turn_cnt clears on the START->KEEPER/SHOOTER transition.
- link_lost clears on the same START->KEEPER/SHOOTER transition.

tx_data, registered, priority:
- left_clicked -> 0xC8
- right_clicked -> 0x28
- game_starts -> 0x48
- turn_timeout being issued this edge -> 0x18
- else 0x08

Undefined codes:
- Any undefined game_state code -> START next cycle with counters cleared.
- rst mid-match overrides everything on that edge.

Test Plan:
- Parameter set for all scenarios: SYNC_CYCLES=8, TURN_TIMEOUT=20, LINK_GRACE=4, RESULT_HOLD=16.
- SOLO flow: solo_enable=1 for 2 cycles, left_clicked -> KEEPER next edge, tx_data=0xC8. match_end=1, match_result=0 -> LOSER. Idle 16 cycles -> START.
- MULTI sync: connect_ok=1, game_starts held high -> START for 8 cycles. Then enemy_shooter=1 -> SHOOTER on the 9th edge.
  - A connect_ok dropout at cycle 5 restarts the count: entry is 8 cycles after connect_ok returns.
- Turn swaps and timeout: in KEEPER pulse end_gk -> SHOOTER, turn_cnt=1. No end_sh for 20 cycles -> turn_timeout pulse, tx_data=0x18, KEEPER, turn_cnt=2.
- Simultaneous events: match_end=1, match_result=1 together with end_gk and timer expiry -> WINNER, turn_timeout stays 0, turn_cnt unchanged.
- Link loss: mid-SHOOTER, connect_ok low for 3 cycles -> no change. Low for 4 consecutive cycles -> START, link_lost=1. link_lost stays high until the next match starts.
- Mode lock and reset: toggle solo_enable during KEEPER -> game_mode unchanged. Assert rst mid-SHOOTER -> START, MULTI, tx_data=0x00, turn_cnt=0 at the next edge.
